pool_2_reader: RTL and testbench
================================

# pool_2_reader

Drains the pooled feature maps that the layer-2 pooling stage has written into its dual-port result RAM, reading through RAM port b, and presents them as a valid/ready stream to the next layer's input loader. Runs one pass per `start` pulse, issued by the layer sequencer after pooling completes. Absorbs the RAM read latency and downstream backpressure with a small credit-controlled skid FIFO. Tags each word with its map index and an end-of-map flag.

## Interface
- `DATA_WIDTH`, 16, pooled word width (unsigned)
- `OUT_FEATURE_WIDTH_POOL`, 12, pooled map side length W
- `NUM_ONEMULT`, 4, number of maps stored back-to-back in the RAM
- `POOL_ADDR_WIDTH`, 10, RAM address width; must hold NUM_ONEMULT*W*W-1
- `MAP_BITWIDTH`, 2, width of map index; must hold NUM_ONEMULT-1
- `RD_LATENCY`, 2, cycles from `rden_b` to valid `q_b`
- `FIFO_DEPTH`, 4, skid FIFO entries; must be ≥ RD_LATENCY+2
- `clk` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `start` in 1 — one-cycle pulse: begin a drain pass; ignored unless idle
- `rden_b` out 1 — RAM port b read enable
- `address_b` out POOL_ADDR_WIDTH — RAM port b address
- `q_b` in DATA_WIDTH — RAM port b read data
- `out_data` out DATA_WIDTH — stream data
- `out_map` out MAP_BITWIDTH — map index of `out_data`
- `out_last` out 1 — `out_data` is the last word (row W-1, col W-1) of its map
- `out_valid` out 1 — stream word available
- `out_ready` in 1 — consumer accepts the word when high with `out_valid`
- `busy` out 1 — high from the cycle after an accepted `start` through the `done` cycle
- `done` out 1 — one-cycle pulse after the final word is accepted

## Operation
- The RAM layout is linear: addr = map*W*W + row*W + col. This matches the pooling stage's write layout. The reader walks addr 0..TOTAL-1, with TOTAL = NUM_ONEMULT*W*W.
- FSM states:
  - IDLE: `start` leads to READ. The address counter and map/position counters clear to 0.
  - READ: issue reads. After the read with addr TOTAL-1 is issued, go to DRAIN.
  - DRAIN: wait until inflight = 0 and FIFO is empty, then go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Read issue rule: in READ, `rden_b` = 1 iff count + inflight < FIFO_DEPTH.
  - count is the registered FIFO occupancy.
  - inflight is the number of reads issued in the last RD_LATENCY cycles.
  - Each issued read increments the address.
- A RD_LATENCY-deep shift register of valid bits and tags (map index, last flag) tracks in-flight reads. When a valid bit emerges, `q_b` and its tags are written into the FIFO.
  - By construction the FIFO never overflows. The bench asserts this.
- FIFO head drives `out_data`, `out_map` and `out_last`. `out_valid` = FIFO non-empty. A pop occurs on `out_valid && out_ready`.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Tag counters are a position counter 0..W*W-1 and a map counter.
  - Position wraps at W*W-1; at that point the map counter increments.
  - `out_last` is the tag of the read at position W*W-1.
- `start` while not IDLE is ignored, with no restart. `out_ready` low never drops or duplicates words.
- `rden_b` is never asserted outside READ. This block never writes the RAM.
- Reset values (including reset mid-pass):
  - state IDLE; `rden_b`, `out_valid`, `busy`, `done` = 0.
  - `address_b`, `out_data`, `out_map` = 0; `out_last` = 0.
  - FIFO empty, in-flight valid bits cleared, so in-flight data is discarded.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: state READ, `busy` = 1, first `rden_b` with addr 0.
- Cycle 1+RD_LATENCY: `q_b` valid and pushed at the end of that cycle.
- Cycle 2+RD_LATENCY: `out_valid` = 1. With defaults this is cycle 4.
- With `out_ready` held high: one word per cycle, no bubbles. The last word appears at cycle TOTAL+1+RD_LATENCY.
- `done` is asserted the cycle after the last pop. `busy` drops with `done`.
- Earliest next accepted `start` is the cycle after `done`.
- Stall: when `out_ready` is low, reads stop once count + inflight reaches FIFO_DEPTH. Reads resume the cycle after a pop frees a credit.
- All outputs are registered or driven from registered state. There are no combinational paths from `out_ready` to `rden_b`.

## Test plan
- Fill RAM with addr value; pulse `start`; hold `out_ready` = 1. Expect:
  - 576 words 0..575 on consecutive cycles starting at cycle 4;
  - `out_map` steps 0→3 every 144 words;
  - `out_last` on words 143/287/431/575;
  - `done` at cycle 580.
- Random `out_ready` (50%). Expect:
  - identical ordered sequence, no loss or duplication;
  - FIFO occupancy never exceeds 4;
  - `rden_b` low whenever count + inflight = 4.
- `out_ready` = 0 for 20 cycles after start. Expect:
  - exactly 4 reads issued (addr 0..3), then `rden_b` low;
  - after release, words 0,1,2,3,4… contiguous.
- `start` pulsed again at cycle 100 of a pass. Expect the pass unaffected: 576 words and a single `done`.
- `reset` asserted at cycle 50 with reads in flight. Expect:
  - next cycle all outputs at reset values, `out_valid` = 0 and stays 0;
  - a new `start` replays from addr 0.
- Back-to-back passes with `start` the cycle after `done`. Expect two full 576-word sequences and two `done` pulses.

Source files
------------

// File: rtl/pool_2_reader.sv
// Streams the layer-2 pooled maps out of the result RAM (port b) as a valid/ready stream.
// Reads are credit-limited so the skid FIFO always has room for every word still in flight.
module pool_2_reader #(
  parameter int DATA_WIDTH             = 16,
  parameter int OUT_FEATURE_WIDTH_POOL = 12,
  parameter int NUM_ONEMULT            = 4,
  parameter int POOL_ADDR_WIDTH        = 10,
  parameter int MAP_BITWIDTH           = 2,
  parameter int RD_LATENCY             = 2,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       rden_b,
  output logic [POOL_ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0]      q_b,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [MAP_BITWIDTH-1:0]    out_map,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int MAP_SZ = OUT_FEATURE_WIDTH_POOL * OUT_FEATURE_WIDTH_POOL;
  localparam int TOTAL  = NUM_ONEMULT * MAP_SZ;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int POSW   = $clog2(MAP_SZ);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;

  logic [POOL_ADDR_WIDTH-1:0] addr;
  logic [POSW-1:0]            pos;
  logic [MAP_BITWIDTH-1:0]    map;

  logic [RD_LATENCY:1]                   vld_pipe;
  logic [RD_LATENCY:1][MAP_BITWIDTH-1:0] map_pipe;
  logic [RD_LATENCY:1]                   last_pipe;

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]   fifo_data;
  logic [FIFO_DEPTH-1:0][MAP_BITWIDTH-1:0] fifo_map;
  logic [FIFO_DEPTH-1:0]                   fifo_last;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next, inflight;
  logic          push, pop, at_last, pos_last;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign push       = vld_pipe[RD_LATENCY];
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign count_next = count + CW'(push) - CW'(pop);
  // Credits cover both FIFO contents and reads whose data has not landed yet.
  assign rden_b     = (state == READ) && ((count + inflight) < CW'(FIFO_DEPTH));
  assign address_b  = addr;
  assign at_last    = (addr == POOL_ADDR_WIDTH'(TOTAL - 1));
  assign pos_last   = (pos == POSW'(MAP_SZ - 1));

  assign out_data = fifo_data[rd_ptr];
  assign out_map  = fifo_map[rd_ptr];
  assign out_last = fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      pos       <= '0;
      map       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_pipe  <= '0;
      map_pipe  <= '0;
      last_pipe <= '0;
      fifo_data <= '0;
      fifo_map  <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      vld_pipe[1]  <= rden_b;
      map_pipe[1]  <= map;
      last_pipe[1] <= pos_last;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        map_pipe[i]  <= map_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end

      if (push) begin
        fifo_data[wr_ptr] <= q_b;
        fifo_map[wr_ptr]  <= map_pipe[RD_LATENCY];
        fifo_last[wr_ptr] <= last_pipe[RD_LATENCY];
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_next;

      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= READ;
          busy  <= 1'b1;
          addr  <= '0;
          pos   <= '0;
          map   <= '0;
        end
        READ: if (rden_b) begin
          if (at_last) state <= DRAIN;
          else         addr  <= addr + 1'b1;
          if (pos_last) begin
            pos <= '0;
            map <= map + 1'b1;
          end else begin
            pos <= pos + 1'b1;
          end
        end
        // Look ahead at count_next so done lands the cycle right after the final pop.
        DRAIN: if (inflight == '0 && count_next == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_2_reader.sv
// Randomized and directed bench for pool_2_reader against a RAM model and an address-order scoreboard.
module tb_pool_2_reader;
  localparam int W     = 12;
  localparam int MAPSZ = W * W;
  localparam int TOTAL = 4 * MAPSZ;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        rden_b, out_last, out_valid, busy, done;
  logic [9:0]  address_b;
  logic [15:0] q_b, out_data;
  logic [1:0]  out_map;

  logic [15:0] ram [0:TOTAL-1];
  logic [9:0]  a1;

  int checks = 0, errors = 0;
  int cyc = 0, issued = 0, popped = 0, first_v = -1, done_cyc = -1, done_cnt = 0;
  bit active = 1'b0;

  pool_2_reader dut (
    .clk(clk), .reset(reset), .start(start), .rden_b(rden_b), .address_b(address_b),
    .q_b(q_b), .out_data(out_data), .out_map(out_map), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-cycle read RAM: address captured, then data registered.
  always @(posedge clk) begin
    a1  <= address_b;
    q_b <= ram[a1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: word i of a pass is ram[i], map i/MAPSZ, last at the final position of each map.
  initial begin : mon
    bit exp_rden;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        issued = 0;
        popped = 0;
      end else begin
        cyc++;
        if (start && !busy) begin
          cyc = 0; issued = 0; popped = 0; active = 1'b1;
          first_v = -1; done_cyc = -1; done_cnt = 0;
        end
        exp_rden = active && busy && (issued < TOTAL) && ((issued - popped) < DEPTH);
        chk("rden", 32'(rden_b), 32'(exp_rden));
        if (rden_b) begin
          chk("addr", 32'(address_b), 32'(issued));
          issued++;
        end
        chk("occupancy", 32'((issued - popped) <= DEPTH), 32'd1);
        if (out_valid && out_ready) begin
          if (first_v < 0) first_v = cyc;
          if (popped < TOTAL) begin
            chk("data", 32'(out_data), 32'(ram[popped]));
            chk("map", 32'(out_map), 32'(popped / MAPSZ));
            chk("last", 32'(out_last), 32'((popped % MAPSZ) == MAPSZ - 1));
          end else begin
            chk("extra_word", 32'(popped), 32'(TOTAL - 1));
          end
          popped++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_all", 32'(popped), 32'(TOTAL));
        end
      end
    end
  end

  // Caller must be at posedge+1; start is driven in the current cycle (cycle 0).
  task automatic run_pass(input int mode, input int restart_at, input bit settle);
    int n;
    bit got;
    got = 1'b0;
    start = 1'b1;
    out_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!got && n < 5000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (n > 20);
      endcase
      start = (n == restart_at);
      if (mode == 2 && n == 21) chk("stall_reads", 32'(issued), 32'd4);
      @(posedge clk); #1;
      n++;
      got = (done_cnt != 0);
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    if (mode == 0) begin
      chk("first_valid_cyc", 32'(first_v), 32'(2 + LAT));
      chk("done_cyc", 32'(done_cyc), 32'(TOTAL + 2 + LAT));
    end
    chk("word_count", 32'(popped), 32'(TOTAL));
    if (settle) begin
      repeat (5) begin @(posedge clk); #1; end
      chk("single_done", 32'(done_cnt), 32'd1);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rden"}, 32'(rden_b), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_addr"}, 32'(address_b), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_map"}, 32'(out_map), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < TOTAL; i++) ram[i] = 16'(i);
    repeat (3) begin @(posedge clk); #1; end
    chk_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("idle");

    run_pass(0, 0, 1'b1);

    for (int i = 0; i < TOTAL; i++) ram[i] = 16'($urandom);
    run_pass(1, 0, 1'b1);
    run_pass(2, 0, 1'b1);
    run_pass(0, 100, 1'b1);

    // Reset while reads and FIFO contents are live.
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outputs("midreset");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("post_reset_valid", 32'(out_valid), 32'd0);
    end
    run_pass(1, 0, 1'b1);

    run_pass(0, 0, 1'b0);
    run_pass(0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
